// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, keeps one imem request in flight, buffers one word for decode.
// Define FETCH_MISALIGN_CHECK_EN to trap misaligned redirect targets in a sticky FAULT state.
package CorePack;
   typedef logic [31:0] inst_t;
endpackage

module inst_fetch
   import CorePack::*;
#(
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   output logic [63:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        inst_valid,
   output inst_t       inst,
   output logic [63:0] inst_pc,
   input  logic        inst_ready,
   output logic        fetch_misalign
);

`ifdef FETCH_MISALIGN_CHECK_EN
   typedef enum logic [2:0] {BOOT, REQ, WAIT, DROP, HOLD, FAULT} state_e;
`else
   typedef enum logic [2:0] {BOOT, REQ, WAIT, DROP, HOLD} state_e;
`endif

   state_e      state_q, state_d;
   logic [63:0] pc_q, pc_d;
   inst_t       inst_q, inst_d;
   logic [63:0] inst_pc_q, inst_pc_d;
   logic [63:0] redirect_tgt;

`ifdef FETCH_MISALIGN_CHECK_EN
   logic redirect_bad;
   assign redirect_tgt = redirect_pc;
   assign redirect_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
   assign redirect_tgt = redirect_pc & ~64'h3;
`endif

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= BOOT;
         pc_q      <= RESET_PC;
         inst_q    <= '0;
         inst_pc_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         inst_q    <= inst_d;
         inst_pc_q <= inst_pc_d;
      end
   end

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      inst_d         = inst_q;
      inst_pc_d      = inst_pc_q;
      imem_req_valid = 1'b0;
      imem_req_addr  = '0;
      inst_valid     = 1'b0;
      inst           = inst_q;
      inst_pc        = inst_pc_q;
      fetch_misalign = 1'b0;

      case (state_q)
         BOOT: state_d = REQ;
         REQ: begin
            imem_req_valid = !redirect_valid;
            imem_req_addr  = pc_q;
            if (redirect_valid)      pc_d    = redirect_tgt;
            else if (imem_req_ready) state_d = WAIT;
         end
         WAIT: begin
            if (redirect_valid) begin
               pc_d    = redirect_tgt;
               state_d = imem_resp_valid ? REQ : DROP;
            end else if (imem_resp_valid) begin
               inst_d    = imem_resp_data;
               inst_pc_d = pc_q;
               pc_d      = pc_q + 64'd4;
               state_d   = HOLD;
            end
         end
         DROP: begin
            // The orphaned response still has to be drained before a new request may issue.
            if (redirect_valid)  pc_d    = redirect_tgt;
            if (imem_resp_valid) state_d = REQ;
         end
         HOLD: begin
            inst_valid = !redirect_valid;
            if (redirect_valid) begin
               pc_d    = redirect_tgt;
               state_d = REQ;
            end else if (inst_ready) begin
               state_d = REQ;
            end
         end
`ifdef FETCH_MISALIGN_CHECK_EN
         FAULT: begin
            inst           = '0;
            inst_pc        = '0;
            fetch_misalign = 1'b1;
         end
`endif
         default: state_d = BOOT;
      endcase

`ifdef FETCH_MISALIGN_CHECK_EN
      if (redirect_bad && state_q != BOOT && state_q != FAULT) state_d = FAULT;
`endif
   end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios, then random traffic against a
// transaction-level model of the expected fetch stream and a latency-randomised memory.
module tb_inst_fetch;
   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid;
   logic [63:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        inst_valid;
   logic [31:0] inst;
   logic [63:0] inst_pc;
   logic        inst_ready;
   logic        fetch_misalign;

   int n_checks = 0;
   int n_errors = 0;

   // Random-phase model: next PC expected in program order, plus the single memory slot.
   logic [63:0] exp_pc;
   logic [63:0] pend_addr;
   logic        pend;
   int          pend_cnt;
   int          delivered;

   inst_fetch dut (
      .clk             (clk),
      .rst             (rst),
      .imem_req_valid  (imem_req_valid),
      .imem_req_addr   (imem_req_addr),
      .imem_req_ready  (imem_req_ready),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .inst_valid      (inst_valid),
      .inst            (inst),
      .inst_pc         (inst_pc),
      .inst_ready      (inst_ready),
      .fetch_misalign  (fetch_misalign)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive one cycle's inputs after the falling edge, then let outputs settle.
   task automatic drive(input logic rdy, input logic rv, input logic [31:0] rd,
                        input logic redir, input logic [63:0] rpc, input logic ir);
      @(negedge clk);
      imem_req_ready  = rdy;
      imem_resp_valid = rv;
      imem_resp_data  = rd;
      redirect_valid  = redir;
      redirect_pc     = rpc;
      inst_ready      = ir;
      #1;
   endtask

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return a[31:0] ^ {a[63:34], 2'b01};
   endfunction

   initial begin
      rst = 1'b1;
      imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
      redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
      #3;
      check("rst_req_valid", imem_req_valid, 0);
      check("rst_req_addr", imem_req_addr, 0);
      check("rst_inst_valid", inst_valid, 0);
      check("rst_inst", inst, 0);
      check("rst_inst_pc", inst_pc, 0);
      check("rst_misalign", fetch_misalign, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0; imem_req_ready = 1'b1;
      #1;
      check("boot_req_valid", imem_req_valid, 0);
      check("boot_inst_valid", inst_valid, 0);

      // First fetch: accept at T, respond T+1, deliver T+2, next request T+3.
      drive(1, 0, 0, 0, 0, 0);
      check("first_req_valid", imem_req_valid, 1);
      check("first_req_addr", imem_req_addr, 64'h0);
      drive(0, 1, 32'h0000_0013, 0, 0, 0);
      check("wait_inst_valid", inst_valid, 0);
      check("wait_req_valid", imem_req_valid, 0);
      drive(0, 0, 0, 0, 0, 1);
      check("first_inst_valid", inst_valid, 1);
      check("first_inst", inst, 32'h0000_0013);
      check("first_inst_pc", inst_pc, 64'h0);
      drive(1, 0, 0, 0, 0, 0);
      check("second_req_valid", imem_req_valid, 1);
      check("second_req_addr", imem_req_addr, 64'h4);

      // Decode stall in HOLD for five cycles.
      drive(0, 1, 32'h0010_0093, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         drive(0, 0, 0, 0, 0, 0);
         check("stall_inst_valid", inst_valid, 1);
         check("stall_inst", inst, 32'h0010_0093);
         check("stall_inst_pc", inst_pc, 64'h4);
         check("stall_req_valid", imem_req_valid, 0);
      end
      drive(0, 0, 0, 0, 0, 1);
      check("stall_release_valid", inst_valid, 1);
      drive(1, 0, 0, 0, 0, 0);
      check("post_stall_req_valid", imem_req_valid, 1);
      check("post_stall_req_addr", imem_req_addr, 64'h8);

      // Redirect in WAIT; the orphaned response two cycles later is dropped.
      drive(0, 0, 0, 1, 64'h100, 0);
      check("wait_redir_inst_valid", inst_valid, 0);
      drive(0, 0, 0, 0, 0, 0);
      check("drop_req_valid", imem_req_valid, 0);
      drive(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
      check("drop_resp_req_valid", imem_req_valid, 0);
      check("drop_resp_inst_valid", inst_valid, 0);
      drive(1, 0, 0, 0, 0, 0);
      check("redir_req_valid", imem_req_valid, 1);
      check("redir_req_addr", imem_req_addr, 64'h100);
      drive(0, 1, 32'h0000_0513, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 1);
      check("redir_inst_valid", inst_valid, 1);
      check("redir_inst", inst, 32'h0000_0513);
      check("redir_inst_pc", inst_pc, 64'h100);
      drive(1, 0, 0, 0, 0, 0);
      check("redir_next_addr", imem_req_addr, 64'h104);

      // Redirect coincident with the response, then redirect in HOLD.
      drive(0, 1, 32'hBAD0_0001, 1, 64'h200, 1);
      check("coinc_inst_valid", inst_valid, 0);
      drive(1, 0, 0, 0, 0, 1);
      check("coinc_after_inst_valid", inst_valid, 0);
      check("coinc_req_valid", imem_req_valid, 1);
      check("coinc_req_addr", imem_req_addr, 64'h200);
      drive(0, 1, 32'h0000_0613, 0, 0, 0);
      drive(0, 0, 0, 1, 64'h200, 1);
      check("hold_squash_valid", inst_valid, 0);
      drive(1, 0, 0, 0, 0, 1);
      check("hold_squash_after_valid", inst_valid, 0);
      check("hold_redir_req_valid", imem_req_valid, 1);
      check("hold_redir_req_addr", imem_req_addr, 64'h200);

      // Reset while in WAIT; stale response arrives in BOOT and must be ignored.
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_req_valid", imem_req_valid, 0);
      check("midrst_req_addr", imem_req_addr, 0);
      check("midrst_inst_valid", inst_valid, 0);
      check("midrst_inst", inst, 0);
      check("midrst_inst_pc", inst_pc, 0);
      @(negedge clk);
      rst = 1'b0; imem_req_ready = 1'b1; imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_0000;
      inst_ready = 1'b0;
      #1;
      check("boot2_req_valid", imem_req_valid, 0);
      check("boot2_inst_valid", inst_valid, 0);
      drive(1, 0, 0, 0, 0, 0);
      check("restart_req_valid", imem_req_valid, 1);
      check("restart_req_addr", imem_req_addr, 64'h0);
      check("restart_inst_valid", inst_valid, 0);
      drive(0, 1, 32'h0000_0013, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 1);
      check("restart_inst_valid2", inst_valid, 1);
      check("restart_inst", inst, 32'h0000_0013);
      check("restart_inst_pc", inst_pc, 64'h0);

      // Misaligned redirect target.
      drive(0, 0, 0, 1, 64'h102, 0);
      check("mis_redir_req_valid", imem_req_valid, 0);
      drive(0, 0, 0, 0, 0, 0);
`ifdef FETCH_MISALIGN_CHECK_EN
      check("mis_fault_flag", fetch_misalign, 1);
      check("mis_fault_req_valid", imem_req_valid, 0);
      drive(1, 0, 0, 1, 64'h300, 1);
      check("mis_fault_redir_flag", fetch_misalign, 1);
      check("mis_fault_redir_req", imem_req_valid, 0);
      drive(1, 0, 0, 0, 0, 1);
      check("mis_fault_sticky", fetch_misalign, 1);
      check("mis_fault_sticky_req", imem_req_valid, 0);
`else
      check("mis_req_valid", imem_req_valid, 1);
      check("mis_req_addr", imem_req_addr, 64'h100);
      check("mis_flag", fetch_misalign, 0);
`endif

      // Random traffic against the stream model.
      @(negedge clk);
      rst = 1'b1;
      imem_req_ready = 1'b0; imem_resp_valid = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      exp_pc = 64'h0; pend = 1'b0; pend_cnt = 0; pend_addr = '0; delivered = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         logic [63:0] tgt;
         @(negedge clk);
         imem_req_ready = ($urandom_range(0, 3) != 0);
         inst_ready     = ($urandom_range(0, 2) != 0);
         redirect_valid = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 3) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
         else                           tgt = {$urandom, $urandom};
`ifdef FETCH_MISALIGN_CHECK_EN
         tgt[1:0] = 2'b00;
`endif
         redirect_pc = tgt;
         imem_resp_valid = 1'b0;
         imem_resp_data  = $urandom;
         if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
               imem_resp_valid = 1'b1;
               imem_resp_data  = mem_word(pend_addr);
               pend = 1'b0;
            end
         end
         #1;
         if (redirect_valid) begin
            check("rnd_squash_inst_valid", inst_valid, 0);
            check("rnd_squash_req_valid", imem_req_valid, 0);
         end
         if (imem_req_valid && imem_req_ready) begin
            check("rnd_one_outstanding", pend, 0);
            check("rnd_req_addr", imem_req_addr, exp_pc);
            pend      = 1'b1;
            pend_cnt  = $urandom_range(1, 3);
            pend_addr = imem_req_addr;
         end
         if (inst_valid && inst_ready) begin
            check("rnd_inst_pc", inst_pc, exp_pc);
            check("rnd_inst", inst, mem_word(exp_pc));
            exp_pc = exp_pc + 64'd4;
            delivered++;
         end
         if (redirect_valid) exp_pc = tgt & ~64'h3;
      end
      check("rnd_progress", 64'(delivered > 50), 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
